// File: rtl/srt4_pkg.sv
// ---------------------------------------------------------------------------
// srt4_pkg
// Shared definitions for the SRT radix-4 divider control sequencer:
//   - srt4_state_t : sequencer state encoding (3 bits, IDLE = 0)
//   - SRT4_DW      : default operand bus width
//   - SRT4_N_ITER  : default number of radix-4 iterations per division
// ---------------------------------------------------------------------------
package srt4_pkg;

  localparam int SRT4_DW     = 9;
  localparam int SRT4_N_ITER = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CHECK  = 3'd3,
    S_ITER   = 3'd4,
    S_CORR   = 3'd5,
    S_DONE   = 3'd6
  } srt4_state_t;

  // True for every state in which a division is in flight.
  function automatic logic srt4_is_busy(input srt4_state_t s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/srt4_iter_cnt.sv
// ---------------------------------------------------------------------------
// srt4_iter_cnt
// Clearable CW-bit iteration counter with a terminal-count flag.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear, has priority over i_inc
//   i_inc  : advance the count by one
//   o_cnt  : current iteration index
//   o_tc   : high when o_cnt is the last iteration (N_ITER-1)
// ---------------------------------------------------------------------------
module srt4_iter_cnt
  import srt4_pkg::*;
#(
  parameter int CW     = 8,
  parameter int N_ITER = SRT4_N_ITER
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  localparam logic [CW-1:0] LP_LAST = CW'(N_ITER - 1);

  logic [CW-1:0] r_cnt;

  // Iteration index register: clear wins over increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LP_LAST);

endmodule

// File: rtl/srt4_seq.sv
// ---------------------------------------------------------------------------
// srt4_seq
// Control sequencer for the SRT radix-4 divider datapath. Loads dividend and
// divisor over a shared operand bus, runs N_ITER iterations, one correction
// slot, then holds the result until the consumer takes it.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_start               : division request (sampled only in IDLE)
//   i_abort               : synchronous cancel back to IDLE
//   i_op_valid/o_op_ready : operand word handshake on the shared bus
//   o_dmx_sel             : bus demux select (0 dividend, 1 divisor)
//   o_ld_a, o_ld_b        : dividend / divisor register load enables
//   o_clr                 : clear quotient/remainder registers
//   i_div_zero            : datapath flag, loaded divisor is zero
//   o_iter_en, o_iter_cnt : iteration enable and current iteration index
//   i_rem_neg             : datapath flag, final partial remainder negative
//   o_corr_en             : apply remainder/quotient correction
//   o_res_valid/i_res_ready : result handshake
//   o_div_err             : divide-by-zero, qualified by o_res_valid
//   o_busy                : sequencer not idle
// ---------------------------------------------------------------------------
module srt4_seq
  import srt4_pkg::*;
#(
  parameter int DW     = SRT4_DW,
  parameter int N_ITER = SRT4_N_ITER,
  parameter int CW     = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_op_valid,
  output logic          o_op_ready,
  output logic          o_dmx_sel,
  output logic          o_ld_a,
  output logic          o_ld_b,
  output logic          o_clr,
  input  logic          i_div_zero,
  output logic          o_iter_en,
  output logic [CW-1:0] o_iter_cnt,
  input  logic          i_rem_neg,
  output logic          o_corr_en,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic          o_div_err,
  output logic          o_busy
);

  // Reject parameter sets the counter cannot represent.
  if ((DW < 1) || (N_ITER < 1) || (N_ITER > 255) || ((2 ** CW) < N_ITER)) begin : g_param_check
    $error("srt4_seq: illegal parameter set");
  end

  srt4_state_t   r_state;
  srt4_state_t   w_next;
  logic          r_err;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_tc;
  logic [CW-1:0] w_cnt;

  // The counter only runs in ITER; anywhere else (and on abort or the last
  // iteration) it is held at zero so ITER always starts from index 0.
  assign w_cnt_inc = (r_state == S_ITER);
  assign w_cnt_clr = i_abort | (r_state != S_ITER) | w_tc;

  srt4_iter_cnt #(
    .CW     (CW),
    .N_ITER (N_ITER)
  ) u_iter_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = i_start    ? S_LOAD_A : S_IDLE;
        S_LOAD_A: w_next = i_op_valid ? S_LOAD_B : S_LOAD_A;
        S_LOAD_B: w_next = i_op_valid ? S_CHECK  : S_LOAD_B;
        S_CHECK:  w_next = i_div_zero ? S_DONE   : S_ITER;
        S_ITER:   w_next = w_tc       ? S_CORR   : S_ITER;
        S_CORR:   w_next = S_DONE;
        S_DONE:   w_next = i_res_ready ? S_IDLE  : S_DONE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Divide-by-zero flag: captured in CHECK, dropped on handshake or abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (i_abort) begin
      r_err <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_err <= i_div_zero;
    end else if ((r_state == S_DONE) && i_res_ready) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  // Output decode: Moore from state; the enables that touch datapath
  // registers are additionally gated off in an abort cycle.
  always_comb begin
    o_op_ready  = 1'b0;
    o_dmx_sel   = 1'b0;
    o_ld_a      = 1'b0;
    o_ld_b      = 1'b0;
    o_clr       = 1'b0;
    o_iter_en   = 1'b0;
    o_corr_en   = 1'b0;
    o_res_valid = 1'b0;
    o_div_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_clr = i_start & ~i_abort;
      end
      S_LOAD_A: begin
        o_op_ready = 1'b1;
        o_ld_a     = i_op_valid & ~i_abort;
      end
      S_LOAD_B: begin
        o_op_ready = 1'b1;
        o_dmx_sel  = 1'b1;
        o_ld_b     = i_op_valid & ~i_abort;
      end
      S_ITER: begin
        o_iter_en = ~i_abort;
      end
      S_CORR: begin
        o_corr_en = i_rem_neg & ~i_abort;
      end
      S_DONE: begin
        o_res_valid = 1'b1;
        o_div_err   = r_err;
      end
      default: begin
        o_op_ready = 1'b0;
      end
    endcase
    o_busy = srt4_is_busy(r_state);
  end

  assign o_iter_cnt = w_cnt;

endmodule

// File: tb/tb_srt4_seq.sv
module tb_srt4_seq;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst;
  logic i_start, i_abort, i_op_valid, i_div_zero, i_rem_neg, i_res_ready;
  logic o_op_ready, o_dmx_sel, o_ld_a, o_ld_b, o_clr, o_iter_en, o_corr_en;
  logic o_res_valid, o_div_err, o_busy;
  logic [CW-1:0] o_iter_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  srt4_seq #(.DW(9), .N_ITER(N), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .o_dmx_sel(o_dmx_sel),
    .o_ld_a(o_ld_a), .o_ld_b(o_ld_b), .o_clr(o_clr), .i_div_zero(i_div_zero),
    .o_iter_en(o_iter_en), .o_iter_cnt(o_iter_cnt), .i_rem_neg(i_rem_neg),
    .o_corr_en(o_corr_en), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_div_err(o_div_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // One transaction: stall lengths, datapath flags and expected outcome.
  typedef struct {
    int wa, wb, dz, rn, rw;
    int exp_tr, exp_iters, exp_corr, exp_err, exp_rvlen;
  } vec_t;

  // Per-cycle trace of one transaction.
  bit rec_rdy[MAXC], rec_dmx[MAXC], rec_lda[MAXC], rec_ldb[MAXC], rec_clr[MAXC];
  bit rec_it[MAXC], rec_corr[MAXC], rec_rv[MAXC], rec_err[MAXC], rec_busy[MAXC];
  int rec_cnt[MAXC];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({o_op_ready, o_dmx_sel, o_ld_a, o_ld_b, o_clr, o_iter_en,
                 o_corr_en, o_res_valid, o_div_err, o_busy});
  endfunction

  task automatic drive(input bit st, input bit ab, input bit ov, input bit dz,
                       input bit rn, input bit rr);
    i_start = st; i_abort = ab; i_op_valid = ov;
    i_div_zero = dz; i_rem_neg = rn; i_res_ready = rr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: timing of one division from its stall lengths and flags.
  function automatic vec_t model(input int wa, wb, dz, rn, rw);
    vec_t v;
    int tc;
    v.wa = wa; v.wb = wb; v.dz = dz; v.rn = rn; v.rw = rw;
    tc = 3 + wa + wb;
    v.exp_tr    = (dz != 0) ? tc + 1 : tc + N + 2;
    v.exp_iters = (dz != 0) ? 0 : N;
    v.exp_corr  = (dz != 0) ? 0 : rn;
    v.exp_err   = dz;
    v.exp_rvlen = rw + 1;
    return v;
  endfunction

  // Drive one division starting in IDLE (start in cycle 0), trace it, compare.
  task automatic run_txn(input vec_t v, input bit rand_start, input string tag);
    int tc, tld_a, tld_b, tend, ncyc;
    int n_clr, n_lda, f_lda, n_ldb, f_ldb, n_both, n_it, f_it, bad_cnt;
    int n_corr, f_corr, n_rv, f_rv, err_at, err_stray, bad_busy, bad_rdy, bad_dmx;
    bit busy_exp, rdy_exp, dmx_exp;
    tc    = 3 + v.wa + v.wb;
    tld_a = 1 + v.wa;
    tld_b = 2 + v.wa + v.wb;
    tend  = v.exp_tr + v.rw;
    ncyc  = (tend + 3 > MAXC) ? MAXC : tend + 3;
    for (int c = 0; c < ncyc; c++) begin
      i_abort = 1'b0;
      if (c == 0) i_start = 1'b1;
      else if (rand_start && c <= tend) i_start = 1'($urandom);
      else i_start = 1'b0;
      if ((c >= 1 && c < tld_a) || (c >= 2 + v.wa && c < tld_b)) i_op_valid = 1'b0;
      else if (c == tld_a || c == tld_b) i_op_valid = 1'b1;
      else i_op_valid = 1'($urandom);
      i_div_zero = (c == tc) ? 1'(v.dz) : 1'($urandom);
      i_rem_neg  = (c == tc + N + 1) ? 1'(v.rn) : 1'($urandom);
      if (c < v.exp_tr) i_res_ready = 1'($urandom);
      else i_res_ready = (c == tend) ? 1'b1 : 1'b0;
      @(negedge clk);
      rec_rdy[c] = o_op_ready; rec_dmx[c] = o_dmx_sel; rec_lda[c] = o_ld_a;
      rec_ldb[c] = o_ld_b; rec_clr[c] = o_clr; rec_it[c] = o_iter_en;
      rec_corr[c] = o_corr_en; rec_rv[c] = o_res_valid; rec_err[c] = o_div_err;
      rec_busy[c] = o_busy; rec_cnt[c] = int'(o_iter_cnt);
      next_cycle();
    end
    n_clr = 0; n_lda = 0; f_lda = -1; n_ldb = 0; f_ldb = -1; n_both = 0;
    n_it = 0; f_it = -1; bad_cnt = 0; n_corr = 0; f_corr = -1; n_rv = 0; f_rv = -1;
    err_at = -1; err_stray = 0; bad_busy = 0; bad_rdy = 0; bad_dmx = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (rec_clr[c]) n_clr++;
      if (rec_lda[c]) begin n_lda++; if (f_lda < 0) f_lda = c; end
      if (rec_ldb[c]) begin n_ldb++; if (f_ldb < 0) f_ldb = c; end
      if (rec_lda[c] && rec_ldb[c]) n_both++;
      if (rec_it[c]) begin
        n_it++;
        if (f_it < 0) f_it = c;
        if (rec_cnt[c] != c - (tc + 1)) bad_cnt++;
      end
      if (rec_corr[c]) begin n_corr++; if (f_corr < 0) f_corr = c; end
      if (rec_rv[c]) begin
        n_rv++;
        if (f_rv < 0) begin f_rv = c; err_at = int'(rec_err[c]); end
      end else if (rec_err[c]) err_stray++;
      busy_exp = (c >= 1 && c <= tend);
      rdy_exp  = (c >= 1 && c <= tld_b);
      dmx_exp  = (c >= 2 + v.wa && c <= tld_b);
      if (rec_busy[c] != busy_exp) bad_busy++;
      if (rec_rdy[c] != rdy_exp) bad_rdy++;
      if (rec_dmx[c] != dmx_exp) bad_dmx++;
    end
    chk({tag, " clr_c0"}, int'(rec_clr[0]), 1);
    chk({tag, " clr_count"}, n_clr, 1);
    chk({tag, " ld_a_count"}, n_lda, 1);
    chk({tag, " ld_a_cycle"}, f_lda, tld_a);
    chk({tag, " ld_b_count"}, n_ldb, 1);
    chk({tag, " ld_b_cycle"}, f_ldb, tld_b);
    chk({tag, " ld_overlap"}, n_both, 0);
    chk({tag, " op_ready_trace"}, bad_rdy, 0);
    chk({tag, " dmx_sel_trace"}, bad_dmx, 0);
    chk({tag, " iter_en_count"}, n_it, v.exp_iters);
    if (v.exp_iters > 0) chk({tag, " iter_en_first"}, f_it, tc + 1);
    chk({tag, " iter_cnt_seq"}, bad_cnt, 0);
    chk({tag, " corr_en_count"}, n_corr, v.exp_corr);
    if (v.exp_corr > 0) chk({tag, " corr_en_cycle"}, f_corr, tc + N + 1);
    chk({tag, " res_valid_first"}, f_rv, v.exp_tr);
    chk({tag, " res_valid_len"}, n_rv, v.exp_rvlen);
    chk({tag, " div_err"}, err_at, v.exp_err);
    chk({tag, " div_err_stray"}, err_stray, 0);
    chk({tag, " busy_trace"}, bad_busy, 0);
    if (o_busy) do_reset();
  endtask

  vec_t tbl[7];
  vec_t rv;
  int   cnt_rv, cnt_corr;

  initial begin
    // wa wb dz rn rw | tr iters corr err rvlen
    tbl[0] = '{0, 0, 0, 0, 0,  9, 4, 0, 0, 1};  // nominal
    tbl[1] = '{0, 0, 0, 1, 0,  9, 4, 1, 0, 1};  // correction
    tbl[2] = '{0, 0, 1, 0, 0,  4, 0, 0, 1, 1};  // divide by zero
    tbl[3] = '{0, 3, 0, 0, 0, 12, 4, 0, 0, 1};  // LOAD_B stall 3
    tbl[4] = '{0, 0, 0, 1, 5,  9, 4, 1, 0, 6};  // res_ready low 5
    tbl[5] = '{2, 1, 1, 1, 2,  7, 0, 0, 1, 3};  // stalls + div0
    tbl[6] = '{3, 0, 0, 1, 1, 12, 4, 1, 0, 2};  // LOAD_A stall 3

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    chk("reset_iter_cnt", int'(o_iter_cnt), 0);
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], (i >= 3), $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of ITER (cycle 6, iter_cnt=2).
    for (int c = 0; c < 7; c++) begin
      drive((c == 0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (c < 6) next_cycle();
    end
    @(negedge clk);
    chk("pre_rst_iter_en", int'(o_iter_en), 1);
    chk("pre_rst_iter_cnt", int'(o_iter_cnt), 2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", all_outs(), 0);
    chk("async_rst_iter_cnt", int'(o_iter_cnt), 0);
    #1 rst = 1'b0;
    next_cycle();
    run_txn(tbl[0], 1'b0, "after_rst");

    // Abort in the cycle where iter_cnt=2.
    for (int c = 0; c < 7; c++) begin
      drive((c == 0), (c == 6), 1'b1, 1'b0, 1'b1, 1'b1);
      if (c < 6) next_cycle();
    end
    @(negedge clk);
    chk("abort_iter_cnt", int'(o_iter_cnt), 2);
    chk("abort_iter_en", int'(o_iter_en), 0);
    next_cycle();
    cnt_rv = 0; cnt_corr = 0;
    for (int c = 7; c < 15; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      if (c == 7) begin
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_cnt_clear", int'(o_iter_cnt), 0);
      end
      if (o_res_valid) cnt_rv++;
      if (o_corr_en) cnt_corr++;
      next_cycle();
    end
    chk("abort_no_res_valid", cnt_rv, 0);
    chk("abort_no_corr_en", cnt_corr, 0);
    // Abort together with start in IDLE: nothing starts, no clear.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("abort_idle_clr", int'(o_clr), 0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("abort_idle_busy", int'(o_busy), 0);
    next_cycle();
    run_txn(tbl[0], 1'b0, "after_abort");

    // Randomized divisions against the timing model.
    for (int i = 0; i < 25; i++) begin
      rv = model($urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
                 $urandom_range(0, 4));
      run_txn(rv, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
